// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM-stage data-cache request controller with watchdog.
// Optional LL/SC link register is built when MEM_LLSC_EN is defined.
module memory_access_unit #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        mem_rd_i,
   input  logic        mem_wr_i,
   input  logic        mem_ll_i,
   input  logic        mem_sc_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic        flush_i,
   input  logic        link_inv_i,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   output logic [31:0] load_data_o,
   output logic        exmem_enable_o,
   output logic        sc_result_o,
   output logic        misaligned_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

   state_t      state, state_n;
   logic        op_wr, op_rd, aligned;
   logic        sc_ok;
   logic        sc_q, sc_n;
   logic        hit_w;
   logic [15:0] wd_cnt;

   assign op_wr   = mem_wr_i | mem_sc_i;
   assign op_rd   = (mem_rd_i | mem_ll_i) & ~op_wr;
   assign aligned = (mem_addr_i[1:0] == 2'b00);
   assign hit_w   = (state == WAIT) & dhit;

   assign dmemaddr    = mem_addr_i;
   assign dmemstore   = mem_wdata_i;
   assign sc_result_o = (state == DONE) & sc_q;

`ifdef MEM_LLSC_EN
   logic        link_v;
   logic [31:0] link_addr;

   assign sc_ok = link_v & (link_addr == mem_addr_i);

   // Track the LL reservation; invalidate takes priority over a new link.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         link_v    <= 1'b0;
         link_addr <= '0;
      end else begin
         if (hit_w && op_rd && mem_ll_i) begin
            link_v    <= 1'b1;
            link_addr <= mem_addr_i;
         end
         if (hit_w && op_wr && link_v && (mem_addr_i == link_addr))
            link_v <= 1'b0;
         if (link_inv_i)
            link_v <= 1'b0;
      end
   end
`else
   logic unused_link_inv;

   assign sc_ok           = 1'b1;
   assign unused_link_inv = link_inv_i;
`endif

   // State register; reset drops any in-flight request without completion.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         state <= IDLE;
         sc_q  <= 1'b0;
      end else begin
         state <= state_n;
         sc_q  <= sc_n;
      end
   end

   // Next state, request strobes and pipeline enable.
   always_comb begin
      state_n        = state;
      dmemREN        = 1'b0;
      dmemWEN        = 1'b0;
      exmem_enable_o = 1'b1;
      misaligned_o   = 1'b0;
      sc_n           = 1'b0;
      unique case (state)
         IDLE: begin
            if ((op_rd | op_wr) && !flush_i) begin
               if (!aligned) begin
                  misaligned_o = 1'b1;
               end else if (mem_sc_i && !sc_ok) begin
                  state_n        = DONE;
                  exmem_enable_o = 1'b0;
               end else begin
                  state_n        = WAIT;
                  exmem_enable_o = 1'b0;
               end
            end
         end
         WAIT: begin
            dmemREN        = op_rd;
            dmemWEN        = op_wr;
            exmem_enable_o = 1'b0;
            if (dhit) begin
               state_n = DONE;
               sc_n    = mem_sc_i;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (nRST)
         misaligned_o = 1'b0;
   end

   // Capture load data when a read completes; held otherwise.
   always_ff @(posedge CLK) begin
      if (nRST)
         load_data_o <= '0;
      else if (hit_w && op_rd)
         load_data_o <= dmemload;
   end

   // Watchdog: count WAIT cycles without a hit; error is sticky.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         wd_cnt    <= '0;
         timeout_o <= 1'b0;
      end else begin
         if (state == IDLE && state_n == WAIT)
            wd_cnt <= '0;
         else if (state == WAIT && !dhit && wd_cnt != 16'hFFFF)
            wd_cnt <= wd_cnt + 16'd1;
         if (state == WAIT && !dhit && (wd_cnt + 16'd1) >= TO_LIM)
            timeout_o <= 1'b1;
      end
   end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage data-access controller. It sits between the EX/MEM pipeline latch outputs and the data-cache port. It turns a latched load or store into a `dmemREN`/`dmemWEN` request, holds the request until `dhit`, and registers the returned load data. While the access is in flight it drives the EX/MEM latch `enable` low to stall the pipeline. It is the responder-side counterpart of the EX/MEM latch: it consumes the latch outputs and produces the `enable` the latch obeys.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: number of `WAIT` cycles without `dhit` before `timeout_o` sets.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `nRST` in 1: synchronous, active-high reset.
- `mem_rd_i` in 1: load in MEM stage (from the latched `memtoReg`).
- `mem_wr_i` in 1: store in MEM stage (from the latched `memWr`).
- `mem_ll_i` in 1: instruction is LL.
- `mem_sc_i` in 1: instruction is SC.
- `mem_addr_i` in 32: effective address (latched ALU result).
- `mem_wdata_i` in 32: store data (latched `busB`).
- `flush_i` in 1: squash the MEM-stage op.
- `link_inv_i` in 1: external invalidate of the LL link.
- `dhit` in 1: cache access complete.
- `dmemload` in 32: cache read data.
- `dmemREN` out 1: read request.
- `dmemWEN` out 1: write request.
- `dmemaddr` out 32: request address.
- `dmemstore` out 32: write data.
- `load_data_o` out 32: registered load result.
- `exmem_enable_o` out 1: advance enable to the EX/MEM latch and upstream stages.
- `sc_result_o` out 1: SC success flag, valid when `exmem_enable_o`=1.
- `misaligned_o` out 1: one-cycle pulse on an unaligned access.
- `timeout_o` out 1: sticky watchdog error.

## Operation
- The FSM has three states: `IDLE`, `WAIT`, `DONE`.
- Op decode: `op_wr = mem_wr_i | mem_sc_i`; `op_rd = (mem_rd_i | mem_ll_i) & ~op_wr`. When both a read and a write are asserted, the write wins.
- `IDLE`:
  - No op, or `flush_i`=1: no request, `exmem_enable_o`=1.
  - `mem_addr_i[1:0]`≠0: no request, `misaligned_o`=1, `exmem_enable_o`=1 (the op is dropped as a NOP).
  - Otherwise: go to `WAIT`. `exmem_enable_o`=0.
- `WAIT`:
  - `dmemREN`=`op_rd` and `dmemWEN`=`op_wr`, asserted combinationally from the held latch inputs.
  - `dmemaddr`=`mem_addr_i`, `dmemstore`=`mem_wdata_i`.
  - `exmem_enable_o`=0.
  - On `dhit`: `load_data_o`<=`dmemload` (reads only), then go to `DONE`.
  - `flush_i` is ignored in `WAIT`; a started access always completes.
- `DONE`:
  - Requests deasserted, `exmem_enable_o`=1, go to `IDLE`.
  - `load_data_o` holds its value until the next read completes.
- Watchdog:
  - A 16-bit counter clears on entry to `WAIT` and increments each `WAIT` cycle without `dhit`.
  - When the count reaches `TIMEOUT_CYCLES`, `timeout_o` sets and stays set until reset. The FSM keeps waiting.
- Reset outputs:
  - FSM=`IDLE`; `load_data_o`=0; `timeout_o`=0; `sc_result_o`=0; `misaligned_o`=0; link cleared.
  - Request outputs are 0; `exmem_enable_o`=1 when there is no op.
  - Reset asserted in `WAIT` drops the request at the next edge with no completion.

## Timing
- A hit on the first `WAIT` cycle (cycle N) gives this sequence:
  - cycle N−1: `IDLE`, op seen.
  - cycle N: `WAIT`, request up, `dhit`=1.
  - cycle N+1: `DONE`, enable=1.
- Minimum stall is 2 cycles per memory op. This is deliberate: there is no combinational path from `dhit` to `exmem_enable_o`.
- `dmemaddr`, `dmemstore`, `dmemREN` and `dmemWEN` are stable for every cycle of `WAIT`.
- An op arriving while in `DONE` is accepted in the following `IDLE` cycle.

## Configuration
Macro `MEM_LLSC_EN`.

When defined:
- A link register (valid bit + 32-bit address) is implemented.
- LL completion sets link valid with `link_addr`=`mem_addr_i`.
- SC with the link valid and the address equal to `link_addr`:
  - Performs the write; `sc_result_o`=1 in `DONE`; clears the link.
- SC that fails the check:
  - Issues no request; takes `IDLE`→`DONE` directly (1 stall cycle); `sc_result_o`=0.
- These events clear the link: `link_inv_i`=1, or any completed store to `link_addr`.
- Simultaneous LL set and `link_inv_i`: the invalidate wins.

When not defined:
- LL behaves as an ordinary read and SC as an ordinary write.
- `sc_result_o`=1 on every SC completion.
- `link_inv_i` is ignored.

## Test plan
- Load from 0x100 with `dhit` on the 3rd `WAIT` cycle and `dmemload`=0xDEADBEEF:
  - `dmemREN`=1 for 3 cycles; `load_data_o`=0xDEADBEEF; enable high exactly 1 cycle after the hit.
- Store of 0x12345678 to 0x200:
  - `dmemWEN`=1 and `dmemstore` stable until `dhit`; `dmemREN` stays 0.
- Load at address 0x102:
  - No request; `misaligned_o` pulses once; enable=1 in the same cycle.
- `flush_i` raised in `IDLE` with a store pending: no `dmemWEN`.
- `flush_i` raised mid-`WAIT`: the access completes normally.
- `nRST` asserted in `WAIT`:
  - Request is 0 at the next edge; `timeout_o`=0.
  - With `TIMEOUT_CYCLES`=4 and no `dhit`, `timeout_o` sets after 4 `WAIT` cycles and stays set.
- With `MEM_LLSC_EN`:
  - LL 0x300, then SC 0x300: `sc_result_o`=1 and a write is issued.
  - LL 0x300, `link_inv_i`, then SC 0x300: `sc_result_o`=0 and no `dmemWEN`.
